// File: rtl/dm_arbiter.sv
// dm_arbiter
// ----------
// Two-requester arbiter in front of a single-port 1K-word data memory
// (async read, write on posedge clk). Port A is the CPU load/store stage,
// port B is a debug/DMA loader. One access is granted per cycle. On a
// conflict the grant alternates round-robin. A requester may hold the
// grant with a lock burst, which is bounded to MAX_BURST cycles while
// the other side is waiting.
//
// Handshake: x_req_i is the request ("valid"). x_gnt_o is the same-cycle
// acceptance ("ready"). An access happens in exactly the cycle where both
// are high, and the requester must hold its request until it sees x_gnt_o.
// A granted read returns x_rdata_o with x_rvalid_o one cycle later.
// A granted write has no response.
//
// Ports:
//   clk_i, rst_i            clock; synchronous active-high reset
//   a_req_i/a_we_i/a_lock_i request, write flag, keep-grant-next-cycle
//   a_addr_i[11:2]          word address
//   a_wdata_i               write data
//   a_gnt_o                 access performed this cycle
//   a_rvalid_o, a_rdata_o   registered read response
//   b_*                     same as a_* for port B
//   m_addr_o, m_din_o       memory address and write data
//   m_we_o                  memory write enable
//   m_dout_i                memory read data (combinational from m_addr_o)
//   a/b_wait_cnt_o[15:0]    only when DM_ARB_STAT_EN is defined:
//                           saturating count of cycles spent requesting
//                           without a grant
//   dbg_state_o[1:0]        FSM state (0 = IDLE, 1 = LOCK_A, 2 = LOCK_B)
//
// Optional feature macro: DM_ARB_STAT_EN (adds the wait counters).

module dm_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_req_i,
  input  logic        a_we_i,
  input  logic        a_lock_i,
  input  logic [11:2] a_addr_i,
  input  logic [31:0] a_wdata_i,
  output logic        a_gnt_o,
  output logic        a_rvalid_o,
  output logic [31:0] a_rdata_o,
  input  logic        b_req_i,
  input  logic        b_we_i,
  input  logic        b_lock_i,
  input  logic [11:2] b_addr_i,
  input  logic [31:0] b_wdata_i,
  output logic        b_gnt_o,
  output logic        b_rvalid_o,
  output logic [31:0] b_rdata_o,
  output logic [11:2] m_addr_o,
  output logic [31:0] m_din_o,
  output logic        m_we_o,
  input  logic [31:0] m_dout_i,
`ifdef DM_ARB_STAT_EN
  output logic [15:0] a_wait_cnt_o,
  output logic [15:0] b_wait_cnt_o,
`endif
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOCK_A = 2'd1,
    S_LOCK_B = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             last_q, last_d;     // 1: B had the most recent grant
  logic [CNT_W-1:0] burst_q, burst_d;

  logic             gnt_a, gnt_b;       // raw grants before reset gating
  logic             a_gnt, b_gnt;       // final grants
  logic             arb_a, arb_b;       // round-robin pick from IDLE rules
  logic             burst_full;
  logic             do_arb;

  // A tie goes to the port that did not have the most recent grant.
  assign arb_a      = a_req_i & (~b_req_i | last_q);
  assign arb_b      = b_req_i & (~a_req_i | ~last_q);
  assign burst_full = (burst_q == BURST_MAX);

  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    do_arb  = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;

    case (state_q)
      S_LOCK_A: begin
        if (!a_req_i) begin
          do_arb = 1'b1;
        end else if (burst_full && b_req_i) begin
          // Burst exhausted with B waiting: B takes this cycle.
          gnt_b  = 1'b1;
          last_d = 1'b1;
          if (b_lock_i) begin
            state_d = S_LOCK_B;
            burst_d = BURST_ONE;
          end else begin
            state_d = S_IDLE;
            burst_d = '0;
          end
        end else begin
          gnt_a  = 1'b1;
          last_d = 1'b0;
          if (a_lock_i) begin
            state_d = S_LOCK_A;
            burst_d = burst_full ? burst_q : burst_q + BURST_ONE;
          end else begin
            state_d = S_IDLE;
            burst_d = '0;
          end
        end
      end
      S_LOCK_B: begin
        if (!b_req_i) begin
          do_arb = 1'b1;
        end else if (burst_full && a_req_i) begin
          gnt_a  = 1'b1;
          last_d = 1'b0;
          if (a_lock_i) begin
            state_d = S_LOCK_A;
            burst_d = BURST_ONE;
          end else begin
            state_d = S_IDLE;
            burst_d = '0;
          end
        end else begin
          gnt_b  = 1'b1;
          last_d = 1'b1;
          if (b_lock_i) begin
            state_d = S_LOCK_B;
            burst_d = burst_full ? burst_q : burst_q + BURST_ONE;
          end else begin
            state_d = S_IDLE;
            burst_d = '0;
          end
        end
      end
      default: do_arb = 1'b1;
    endcase

    // Plain arbitration: used from IDLE, and from a lock state whose owner
    // dropped its request.
    if (do_arb) begin
      gnt_a   = arb_a;
      gnt_b   = arb_b;
      state_d = S_IDLE;
      burst_d = '0;
      if (arb_a) begin
        last_d = 1'b0;
        if (a_lock_i) begin
          state_d = S_LOCK_A;
          burst_d = BURST_ONE;
        end
      end else if (arb_b) begin
        last_d = 1'b1;
        if (b_lock_i) begin
          state_d = S_LOCK_B;
          burst_d = BURST_ONE;
        end
      end
    end
  end

  // No access may reach the memory while reset is held.
  assign a_gnt = gnt_a & ~rst_i;
  assign b_gnt = gnt_b & ~rst_i;

  always_comb begin
    m_addr_o = '0;
    m_din_o  = '0;
    m_we_o   = 1'b0;
    if (a_gnt) begin
      m_addr_o = a_addr_i;
      m_din_o  = a_wdata_i;
      m_we_o   = a_we_i;
    end else if (b_gnt) begin
      m_addr_o = b_addr_i;
      m_din_o  = b_wdata_i;
      m_we_o   = b_we_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      burst_q    <= '0;
      a_rvalid_o <= 1'b0;
      a_rdata_o  <= '0;
      b_rvalid_o <= 1'b0;
      b_rdata_o  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
      a_rvalid_o <= a_gnt & ~a_we_i;
      b_rvalid_o <= b_gnt & ~b_we_i;
      if (a_gnt && !a_we_i) a_rdata_o <= m_dout_i;
      if (b_gnt && !b_we_i) b_rdata_o <= m_dout_i;
    end
  end

`ifdef DM_ARB_STAT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_wait_cnt_o <= '0;
      b_wait_cnt_o <= '0;
    end else begin
      if (a_req_i && !a_gnt && a_wait_cnt_o != 16'hFFFF)
        a_wait_cnt_o <= a_wait_cnt_o + 16'd1;
      if (b_req_i && !b_gnt && b_wait_cnt_o != 16'hFFFF)
        b_wait_cnt_o <= b_wait_cnt_o + 16'd1;
    end
  end
`endif

  assign a_gnt_o     = a_gnt;
  assign b_gnt_o     = b_gnt;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [11:2] a_addr, b_addr, m_addr;
  logic [31:0] a_wdata, b_wdata, m_din, m_dout;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, m_we;
  logic [31:0] a_rdata, b_rdata;
  logic [1:0]  dbg_state;
`ifdef DM_ARB_STAT_EN
  logic [15:0] a_wait_cnt, b_wait_cnt;
`endif

  // Memory behind the arbiter: async read, write on posedge.
  logic [31:0] mem [1024];
  assign m_dout = mem[m_addr];
  always @(posedge clk) if (m_we) mem[m_addr] <= m_din;

  dm_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_lock_i(a_lock), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_lock_i(b_lock), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .m_addr_o(m_addr), .m_din_o(m_din), .m_we_o(m_we), .m_dout_i(m_dout),
`ifdef DM_ARB_STAT_EN
    .a_wait_cnt_o(a_wait_cnt), .b_wait_cnt_o(b_wait_cnt),
`endif
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drv_a(input logic req, we, lock, input logic [9:0] addr, input logic [31:0] wd);
    a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = wd;
  endtask

  task automatic drv_b(input logic req, we, lock, input logic [9:0] addr, input logic [31:0] wd);
    b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = wd;
  endtask

  // Inputs change 1 time unit after posedge; combinational outputs are
  // sampled 2 units later, registered outputs 1 unit after the next posedge.
  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drv_a(0, 0, 0, 10'h0, 32'h0);
    drv_b(0, 0, 0, 10'h0, 32'h0);
    do_reset();

    // Reset state
    settle();
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_state", dbg_state, 0);
    chk("idle_m_addr", m_addr, 0);
    chk("idle_m_din", m_din, 0);
    chk("idle_m_we", m_we, 0);

    // A write 0x004 then A read 0x004
    drv_a(1, 1, 0, 10'h004, 32'hDEADBEEF);
    settle();
    chk("wr_a_gnt", a_gnt, 1);
    chk("wr_b_gnt", b_gnt, 0);
    chk("wr_m_we", m_we, 1);
    chk("wr_m_addr", m_addr, 32'h004);
    chk("wr_m_din", m_din, 32'hDEADBEEF);
    tick();
    chk("wr_no_rvalid", a_rvalid, 0);
    drv_a(1, 0, 0, 10'h004, 32'h0);
    settle();
    chk("rd_a_gnt", a_gnt, 1);
    chk("rd_m_we", m_we, 0);
    tick();
    drv_a(0, 0, 0, 10'h0, 32'h0);
    chk("rd_a_rvalid", a_rvalid, 1);
    chk("rd_a_rdata", a_rdata, 32'hDEADBEEF);
    tick();
    chk("rd_rvalid_drop", a_rvalid, 0);
    chk("rd_rdata_hold", a_rdata, 32'hDEADBEEF);

    // Seed two words through the arbiter: A -> 0x001, B -> 0x002
    drv_a(1, 1, 0, 10'h001, 32'h11111111);
    settle();
    chk("seed_a_gnt", a_gnt, 1);
    tick();
    drv_a(0, 0, 0, 10'h0, 32'h0);
    drv_b(1, 1, 0, 10'h002, 32'h22222222);
    settle();
    chk("seed_b_gnt", b_gnt, 1);
    chk("seed_b_m_din", m_din, 32'h22222222);
    tick();
    drv_b(0, 0, 0, 10'h0, 32'h0);

    // Both read, no lock, from reset: A,B,A,B
    do_reset();
    drv_a(1, 0, 0, 10'h001, 32'h0);
    drv_b(1, 0, 0, 10'h002, 32'h0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("rr%0d_a_gnt", i), a_gnt, (i % 2 == 0));
      chk($sformatf("rr%0d_b_gnt", i), b_gnt, (i % 2 == 1));
      tick();
      chk($sformatf("rr%0d_a_rvalid", i), a_rvalid, (i % 2 == 0));
      chk($sformatf("rr%0d_b_rvalid", i), b_rvalid, (i % 2 == 1));
      if (i % 2 == 0) chk($sformatf("rr%0d_a_rdata", i), a_rdata, 32'h11111111);
      else            chk($sformatf("rr%0d_b_rdata", i), b_rdata, 32'h22222222);
    end

    // A lock burst against continuous B: A x4, B x1, A again
    do_reset();
    exp_q = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0};  // 0 = A, 1 = B
    drv_a(1, 0, 1, 10'h001, 32'h0);
    drv_b(1, 0, 0, 10'h002, 32'h0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] who;
      who = exp_q.pop_front();
      settle();
      chk($sformatf("lk%0d_a_gnt", i), a_gnt, (who == 0));
      chk($sformatf("lk%0d_b_gnt", i), b_gnt, (who == 1));
      tick();
    end
    chk("lk_state_after", dbg_state, 1);

    // A lock alone for 10 cycles, then B appears
    do_reset();
    drv_b(0, 0, 0, 10'h0, 32'h0);
    drv_a(1, 0, 1, 10'h003, 32'h0);
    for (int i = 0; i < 10; i++) begin
      settle();
      chk($sformatf("solo%0d_a_gnt", i), a_gnt, 1);
      tick();
    end
    chk("solo_state", dbg_state, 1);
    drv_b(1, 0, 0, 10'h002, 32'h0);
    settle();
    chk("solo_b_gnt", b_gnt, 1);
    chk("solo_a_gnt", a_gnt, 0);
    tick();
    chk("solo_b_rdata", b_rdata, 32'h22222222);

    // Reset in the middle of a B lock
    do_reset();
    drv_a(0, 0, 0, 10'h0, 32'h0);
    drv_b(1, 0, 1, 10'h002, 32'h0);
    tick();
    tick();
    chk("lb_state", dbg_state, 2);
    drv_b(1, 1, 1, 10'h002, 32'hBAD0BAD0);
    rst = 1'b1;
    settle();
    chk("lb_rst_b_gnt", b_gnt, 0);
    chk("lb_rst_a_gnt", a_gnt, 0);
    chk("lb_rst_m_we", m_we, 0);
    tick();
    rst = 1'b0;
    chk("lb_rst_state", dbg_state, 0);
    drv_a(1, 0, 0, 10'h002, 32'h0);
    drv_b(1, 0, 0, 10'h001, 32'h0);
    settle();
    chk("lb_tie_a_gnt", a_gnt, 1);
    chk("lb_tie_b_gnt", b_gnt, 0);
    tick();
    chk("lb_mem_kept", a_rdata, 32'h22222222);

`ifdef DM_ARB_STAT_EN
    // Wait counters: 6 contended cycles split evenly
    do_reset();
    drv_a(1, 0, 0, 10'h001, 32'h0);
    drv_b(1, 0, 0, 10'h002, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    chk("stat_a_wait", a_wait_cnt, 3);
    chk("stat_b_wait", b_wait_cnt, 3);
`endif

    drv_a(0, 0, 0, 10'h0, 32'h0);
    drv_b(0, 0, 0, 10'h0, 32'h0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
